// File: rtl/booth_mult_param.sv
// booth_mult_param: sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Performs one Booth step per clock. Signed mode takes WIDTH steps and unsigned mode
// takes WIDTH+1 steps. The result is registered into high/low and marked by a
// one-cycle mult_end pulse.
// Optional feature macro: BOOTH_MULT_OVF_EN adds the ovf output, which flags a
// product that does not fit in WIDTH bits.
module booth_mult_param #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MultCtrl,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] high,
   output logic [WIDTH-1:0] low,
   output logic             busy,
   output logic             mult_end
`ifdef BOOTH_MULT_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Extended operand width: one extra bit makes unsigned operands positive in two's complement
   localparam int E  = WIDTH + 1;
   // Product register: {accumulator E, multiplier E, guard 1}
   localparam int PW = 2 * E + 1;
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

   state_t                  r_state;
   logic signed [E-1:0]     r_m;
   logic signed [E-1:0]     r_m_neg;
   logic        [PW-1:0]    r_p;
   logic        [CW-1:0]    r_cnt;
   logic                    r_sgn;
   logic        [WIDTH-1:0] r_high;
   logic        [WIDTH-1:0] r_low;
   logic                    r_busy;
   logic                    r_end;

   logic signed [E-1:0]     w_ext_a;
   logic signed [E-1:0]     w_neg_a;
   logic        [E-1:0]     w_ext_b;
   logic        [PW-1:0]    w_p_next;
   logic    [2*WIDTH-1:0]   w_prod;

   // One Booth step: a conditional add or subtract into the accumulator, then an arithmetic shift right
   function automatic logic [PW-1:0] booth_step(input logic [PW-1:0] p,
                                                input logic signed [E-1:0] m,
                                                input logic signed [E-1:0] m_neg);
      logic signed [E-1:0] upper;
      upper = p[PW-1 -: E];
      case (p[1:0])
         2'b01:   upper = upper + m;
         2'b10:   upper = upper + m_neg;
         default: upper = upper;
      endcase
      return {upper[E-1], upper, p[E:1]};
   endfunction

`ifdef BOOTH_MULT_OVF_EN
   // Product does not fit in WIDTH bits (signed: high is not a sign extension of low)
   function automatic logic ovf_of(input logic [2*WIDTH-1:0] prod, input logic sgn);
      if (sgn)
         return prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
      else
         return prod[2*WIDTH-1:WIDTH] != '0;
   endfunction

   logic r_ovf;
   assign ovf = r_ovf;
`endif

   assign w_ext_a  = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
   assign w_neg_a  = -w_ext_a;
   assign w_ext_b  = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
   assign w_p_next = booth_step(r_p, r_m, r_m_neg);
   // Signed mode stops one step early. The skipped step would only be a shift
   // (its two multiplier bits are equal sign bits), so the result is taken one bit higher.
   assign w_prod   = r_sgn ? w_p_next[2*WIDTH+1:2] : w_p_next[2*WIDTH:1];

   assign high     = r_high;
   assign low      = r_low;
   assign busy     = r_busy;
   assign mult_end = r_end;

   // Control FSM, Booth datapath and result registers; reset aborts any running operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_m_neg <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         r_sgn   <= 1'b0;
         r_high  <= '0;
         r_low   <= '0;
         r_busy  <= 1'b0;
         r_end   <= 1'b0;
`ifdef BOOTH_MULT_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_end <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (MultCtrl) begin
                  r_m     <= w_ext_a;
                  r_m_neg <= w_neg_a;
                  r_p     <= {{E{1'b0}}, w_ext_b, 1'b0};
                  r_cnt   <= is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
                  r_sgn   <= is_signed;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_high  <= w_prod[2*WIDTH-1:WIDTH];
                  r_low   <= w_prod[WIDTH-1:0];
                  r_end   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
`ifdef BOOTH_MULT_OVF_EN
                  r_ovf   <= ovf_of(w_prod, r_sgn);
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_param.sv
// Testbench for booth_mult_param (WIDTH=32). Expected products come from a scoreboard
// queue that is filled when a start is accepted and drained on each mult_end pulse.
module tb_booth_mult_param;

   logic        clk;
   logic        reset;
   logic        MultCtrl;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] high;
   logic [31:0] low;
   logic        busy;
   logic        mult_end;
`ifdef BOOTH_MULT_OVF_EN
   logic        ovf;
`endif

   booth_mult_param #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .MultCtrl(MultCtrl),
      .is_signed(is_signed),
      .a(a),
      .b(b),
      .high(high),
      .low(low),
      .busy(busy),
      .mult_end(mult_end)
`ifdef BOOTH_MULT_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ov;
      longint      end_cyc;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   longint      cyc = 0;
   logic [31:0] last_hi = 32'h0;
   logic [31:0] last_lo = 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so that completion latency can be checked
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit sgn, input logic [31:0] x, input logic [31:0] y, input longint end_c);
      exp_t        e;
      logic [63:0] p;
      longint      sp;
      if (sgn) begin
         sp = longint'($signed(x)) * longint'($signed(y));
         p  = sp;
         e.ov = (p[63:32] != {32{p[31]}});
      end else begin
         p  = {32'h0, x} * {32'h0, y};
         e.ov = (p[63:32] != 32'h0);
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.end_cyc = end_c;
      q.push_back(e);
   endtask

   // Scoreboard check on each completion pulse
   always @(negedge clk) begin
      if (mult_end === 1'b1) begin
         chk("end_expected", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("high", 64'(high), 64'(e.hi));
            chk("low", 64'(low), 64'(e.lo));
            chk("latency_cycle", 64'(cyc), 64'(e.end_cyc));
            chk("busy_at_end", 64'(busy), 64'd0);
`ifdef BOOTH_MULT_OVF_EN
            chk("ovf", 64'(ovf), 64'(e.ov));
`endif
            last_hi = e.hi;
            last_lo = e.lo;
         end
      end
   end

   task automatic start_op(input bit sgn, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      MultCtrl  = 1'b1;
      is_signed = sgn;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      push(sgn, x, y, cyc + (sgn ? 32 : 33));
      chk("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk);
      MultCtrl = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = ~sgn;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("done_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      MultCtrl = 1'b0;
      is_signed = 1'b0;
      a = 32'h0;
      b = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_high", 64'(high), 64'd0);
      chk("rst_low", 64'(low), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_end", 64'(mult_end), 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Basic signed and unsigned products, including both corner squares
      start_op(1'b1, 32'd7, 32'hFFFF_FFFD);
      repeat (15) @(negedge clk);
      chk("busy_mid_run", 64'(busy), 64'd1);
      wait_done();
      start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();
      start_op(1'b1, 32'h8000_0000, 32'h8000_0000);
      wait_done();
      start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      wait_done();
      start_op(1'b1, 32'hFFFF_FFFB, 32'd12345);
      wait_done();
      start_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
      wait_done();
      for (int i = 0; i < 3; i++) begin
         start_op(1'(i % 2), $urandom, $urandom);
         wait_done();
      end

      // Results hold while idle
      repeat (5) @(negedge clk);
      chk("hold_high", 64'(high), 64'(last_hi));
      chk("hold_low", 64'(low), 64'(last_lo));

      // A start request while busy is ignored
      start_op(1'b1, 32'd5, 32'd6);
      repeat (8) @(negedge clk);
      MultCtrl = 1'b1;
      is_signed = 1'b1;
      a = 32'd2;
      b = 32'd2;
      @(negedge clk);
      MultCtrl = 1'b0;
      wait_done();
      repeat (40) @(negedge clk);
      chk("ignored_low", 64'(low), 64'h1E);

      // Asynchronous reset in mid-cycle aborts the operation
      start_op(1'b1, 32'd3, 32'd4);
      repeat (11) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_high", 64'(high), 64'd0);
      chk("async_rst_low", 64'(low), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_end", 64'(mult_end), 64'd0);
      q.delete();
      last_hi = 32'h0;
      last_lo = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      start_op(1'b1, 32'd3, 32'd4);
      wait_done();
      chk("fresh_low", 64'(low), 64'hC);

      // MultCtrl held high: back-to-back operations every 33 edges
      @(negedge clk);
      MultCtrl = 1'b1;
      is_signed = 1'b1;
      a = 32'd2;
      b = 32'd3;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         push(1'b1, 32'd2, 32'd3, cyc + 32);
         if (k > 0) begin
            chk("held_high_stable", 64'(high), 64'd0);
            chk("held_low_stable", 64'(low), 64'd6);
         end
         repeat (32) @(posedge clk);
      end
      #1;
      MultCtrl = 1'b0;
      wait_done();
      repeat (40) @(negedge clk);
      chk("final_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
- Parametrised sequential radix-2 Booth multiplier; next generation of the fixed 32-bit multiplier in the ALU/datapath.
- Generalised over operand width.
- Adds a signed/unsigned mode, a busy flag, a one-cycle completion pulse and defined start-while-busy behaviour.
- Product is split into high/low halves for the HI/LO registers.

Parameters:
- WIDTH, 32, operand width in bits (minimum 2); product is 2*WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous reset, active-low.
- MultCtrl  input  1  start request, sampled on rising edge.
- is_signed  input  1  1 = signed x signed; 0 = unsigned x unsigned; sampled with MultCtrl.
- a  input  WIDTH  multiplicand, sampled with MultCtrl.
- b  input  WIDTH  multiplier, sampled with MultCtrl.
- high  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- low  output  WIDTH  product bits [WIDTH-1:0].
- busy  output  1  high while an operation is in progress.
- mult_end  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous, dominates everything): high=0, low=0, busy=0, mult_end=0, state IDLE, iteration counter=0, internal registers cleared.
- Reset asserted mid-operation aborts it; no mult_end is produced.
- States: IDLE, RUN.
- IDLE, MultCtrl=1 at edge E0:
  - Latch operands, extended to E = WIDTH+1 bits: sign-extend if is_signed=1, zero-extend if 0.
  - Load multiplicand register M = ext(a) and negated copy -M (two's complement, E bits).
  - Product register P (2E+1 bits) = {E zeros, ext(b), 1'b0}.
  - Counter = N, where N = WIDTH if is_signed=1, N = WIDTH+1 if is_signed=0.
  - busy=1; next state RUN.
- RUN, each edge, one Booth step:
  - Inspect P[1:0]: 01 adds M to the upper E bits; 10 adds -M to the upper E bits; 00 and 11 make no change.
  - Then arithmetic-shift P right by 1, replicating the MSB.
  - Decrement counter.
- On the edge where the counter reaches 0 (edge EN; latency N edges after E0):
  - {high, low} <= the 2*WIDTH product bits above P's guard bit.
  - mult_end=1, busy=0, next state IDLE.
- mult_end is high for exactly one cycle and drops at edge EN+1.
- high/low hold their last result until the next completion or reset. They never show partial values.
- MultCtrl while busy=1 is ignored: operands are not relatched and the running operation is unaffected.
- MultCtrl asserted on the same edge that mult_end rises: FSM is still RUN on that edge, so the request is ignored; a new start is accepted from edge EN+1.
- MultCtrl held high continuously: a new operation starts at each IDLE edge, i.e. back-to-back operations every N+1 edges.
- Arithmetic:
  - Signed result is exact for all inputs, including (-2^(WIDTH-1)) x (-2^(WIDTH-1)) = 2^(2*WIDTH-2).
  - Unsigned result is exact for all inputs, including (2^WIDTH-1)^2.
- Operand changes after E0 have no effect.

Optional Feature:
- Macro: BOOTH_MULT_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0, updated together with high/low at completion and held until the next completion.
  - ovf=1 when the product does not fit in WIDTH bits:
    - signed: high != WIDTH copies of low[WIDTH-1].
    - unsigned: high != 0.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, is_signed=1, a=7, b=-3, one-cycle MultCtrl -> busy for 32 cycles; mult_end pulses once at edge 32; high=FFFFFFFF, low=FFFFFFEB; ovf=0.
- WIDTH=32, is_signed=0, a=FFFFFFFF, b=FFFFFFFF -> mult_end at edge 33; high=FFFFFFFE, low=00000001; ovf=1.
- WIDTH=8, is_signed=1, a=80, b=80 -> high=40, low=00 after 8 edges; ovf=1. Same operands with is_signed=0 -> high=40, low=00 after 9 edges.
- WIDTH=32, start a=5, b=6; at edge 10 pulse MultCtrl with a=2, b=2 -> ignored; result high=0, low=1E; only one mult_end pulse.
- Start a=3, b=4; drive reset=0 mid-cycle at cycle 12 (asynchronous) -> outputs 0 immediately; after release no mult_end; a fresh start a=3, b=4 -> low=0000000C.
- MultCtrl held high with constant a=2, b=3 -> a mult_end pulse every 33 edges (WIDTH=32, signed); high/low stable at 0/6 between pulses.
